cond_flag_bank: RTL and testbench
=================================

Name: cond_flag_bank

Overview:
- Parametrised successor to the single-set condition flag register.
- Holds NUM_BANKS independent flag sets {N,Z,C,V}, each written by its own ALU/thread context.
- Evaluates a full 16-entry condition code against any selected bank and produces a registered branch/predicate decision.
- Sits between the ALU flag outputs and the branch/predication logic.

Parameters:
- NUM_BANKS, 4, number of independent flag sets (1..16; non-power-of-2 allowed).
- BANK_W, $clog2(NUM_BANKS) with a minimum of 1, width of the bank select fields (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  flag write strobe.
- wr_bank  in  BANK_W  bank to write.
- wr_mask  in  4  per-flag write enable, bit order [3]=N [2]=Z [1]=C [0]=V.
- n, z, c, v  in  1 each  new flag values from the ALU.
- rd_en  in  1  evaluate request.
- rd_bank  in  BANK_W  bank to evaluate.
- cond  in  4  condition code, encoding below.
- out  out  1  registered condition result.
- out_valid  out  1  high for exactly one cycle after each accepted rd_en.
- flags_out  out  4  registered {N,Z,C,V} of the bank evaluated, for debug/trace.

Behaviour:
- Reset (async, rst_n low): every bank flag = 0; out = 0; out_valid = 0; flags_out = 0. Reset mid-operation discards any in-flight evaluation, and out_valid drops immediately.
- Write: at posedge with wr_en=1 and wr_bank<NUM_BANKS, set bank[wr_bank].f = new value where wr_mask bit is 1; unmasked flags hold. wr_bank>=NUM_BANKS → write ignored. wr_mask=0 → no change.
- Evaluate: at posedge with rd_en=1, out <= eval(cond, src), flags_out <= src, out_valid <= 1. Latency is 1 cycle, throughput 1 per cycle, with no backpressure.
- rd_en=0 → out_valid <= 0; out and flags_out hold their previous values.
- rd_bank>=NUM_BANKS → out <= 0, flags_out <= 0, out_valid <= 1.
- src is the stored bank[rd_bank] before this edge's write, unless the bypass described under Optional Feature applies.
- Condition encoding (4-bit):
  - 0 EQUAL: Z
  - 1 NOT_EQUAL: !Z
  - 2 CARRY_SET: C
  - 3 CARRY_CLR: !C
  - 4 NEGATIVE: N
  - 5 POSITIVE: !N
  - 6 OVERFLOW: V
  - 7 NO_OVERFLOW: !V
  - 8 HIGHER: C&!Z
  - 9 LOWER_SAME: !C|Z
  - 10 GREATER_EQ: N==V
  - 11 LESS: N!=V
  - 12 GREATER: !Z&(N==V)
  - 13 LESS_EQ: Z|(N!=V)
  - 14 ALWAYS: 1
  - 15 NEVER: 0
- Simultaneous write and read on different banks are independent. Two writes cannot collide because there is a single write port.
- Flags are not signed or width-extended; each is one bit.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined: when wr_en=1, rd_en=1 and wr_bank==rd_bank (in range), src is the merged value, i.e. masked new flags with unmasked stored flags. The evaluation sees the same-cycle write.
- Undefined: src is always the stored value. A write followed by an evaluation of the same bank needs one idle cycle to observe the new flags.

Decomposition:
- Shared package/define file holds:
  - the 16 condition code constants, extending the existing EQUAL/LESS/GREATER names with the encoding above;
  - the flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module, cond_eval: inputs cond[3:0] and flags[3:0], output 1-bit result. It is reused by the branch unit.
- Bank storage, write masking, bypass mux and output registers live in cond_flag_bank.

Test Plan:
- Reset: assert rst_n=0 mid-run with out=1 → out=0, out_valid=0 immediately. After release, rd_en with cond=ALWAYS on bank 0 → out=1; cond=EQUAL → out=0.
- Bank isolation: write bank 2 {N,Z,C,V}=0100 with mask 1111, then bank 1 = 1000; evaluate bank 2 EQUAL → 1, bank 1 EQUAL → 0, bank 1 LESS → 1, bank 3 GREATER → 0.
- Masked write: bank 0 = 1001 (mask 1111), then write 0110 with mask 0010 → flags_out=1011; LESS → 0, HIGHER → 1.
- Signed compares over all 8 {N,Z,V} combinations with C=0: GREATER, GREATER_EQ, LESS, LESS_EQ match the equations; N=1,V=1,Z=0 → GREATER=1, LESS=0.
- Same-cycle hazard: bank 1 = 0000, then in one cycle write Z=1 (mask 0100) and evaluate bank 1 EQUAL → out=1 with FLAG_BYPASS_EN, out=0 without; the next-cycle evaluation gives 1 in both builds.
- Range/handshake: NUM_BANKS=3, evaluate rd_bank=3 → out=0, out_valid=1 for one cycle; write wr_bank=3 leaves banks 0–2 unchanged; back-to-back rd_en over 4 cycles → out_valid high for 4 consecutive cycles.

Source files
------------

// File: rtl/cond_flag_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cond_flag_bank_pkg
//  Description : Shared definitions for the condition flag bank and the
//                condition evaluator: the 16 condition codes, the flag bit
//                positions inside a {N,Z,C,V} nibble, and the masked-merge
//                helper used by both the bank write path and the bypass path.
//  Revision    : 1.0 - initial multi-bank release
// ============================================================================
package cond_flag_bank_pkg;

    // Condition codes; EQUAL/LESS/GREATER keep their historical names.
    typedef enum logic [3:0] {
        EQUAL       = 4'd0,
        NOT_EQUAL   = 4'd1,
        CARRY_SET   = 4'd2,
        CARRY_CLR   = 4'd3,
        NEGATIVE    = 4'd4,
        POSITIVE    = 4'd5,
        OVERFLOW    = 4'd6,
        NO_OVERFLOW = 4'd7,
        HIGHER      = 4'd8,
        LOWER_SAME  = 4'd9,
        GREATER_EQ  = 4'd10,
        LESS        = 4'd11,
        GREATER     = 4'd12,
        LESS_EQ     = 4'd13,
        ALWAYS      = 4'd14,
        NEVER       = 4'd15
    } cond_e;

    // Bit positions inside a {N,Z,C,V} flag nibble.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Flags selected by mask take the new value, the rest keep the stored one.
    function automatic logic [3:0] merge_flags(input logic [3:0] stored,
                                               input logic [3:0] new_flags,
                                               input logic [3:0] mask);
        return (stored & ~mask) | (new_flags & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_flag_bank_eval.sv
`default_nettype none
// ============================================================================
//  Module      : cond_eval
//  Description : Purely combinational evaluation of a 4-bit condition code
//                against a {N,Z,C,V} flag nibble. Shared with the branch unit.
//  Ports       : cond   [3:0] in  - condition code (cond_e encoding)
//                flags  [3:0] in  - {N,Z,C,V}
//                result       out - condition outcome
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import cond_flag_bank_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       result
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = flags[FLAG_N];
    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_v = flags[FLAG_V];

    always_comb begin
        result = 1'b0;
        case (cond_e'(cond))
            EQUAL:       result = w_z;
            NOT_EQUAL:   result = ~w_z;
            CARRY_SET:   result = w_c;
            CARRY_CLR:   result = ~w_c;
            NEGATIVE:    result = w_n;
            POSITIVE:    result = ~w_n;
            OVERFLOW:    result = w_v;
            NO_OVERFLOW: result = ~w_v;
            HIGHER:      result = w_c & ~w_z;
            LOWER_SAME:  result = ~w_c | w_z;
            GREATER_EQ:  result = (w_n == w_v);
            LESS:        result = (w_n != w_v);
            GREATER:     result = ~w_z & (w_n == w_v);
            LESS_EQ:     result = w_z | (w_n != w_v);
            ALWAYS:      result = 1'b1;
            NEVER:       result = 1'b0;
            default:     result = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cond_flag_bank.sv
`default_nettype none
// ============================================================================
//  Module      : cond_flag_bank
//  Description : NUM_BANKS independent {N,Z,C,V} flag sets with a single
//                masked write port and a single evaluate port producing a
//                registered condition result (1-cycle latency, 1/cycle).
//  Ports       : clk, rst_n (async, active low)
//                wr_en, wr_bank[BANK_W], wr_mask[4], n, z, c, v  - write port
//                rd_en, rd_bank[BANK_W], cond[4]                  - evaluate
//                out, out_valid, flags_out[4]                     - results
//  Options     : FLAG_BYPASS_EN - same-cycle write to the evaluated bank is
//                forwarded into the evaluation.
//  Revision    : 1.0 - initial multi-bank release
// ============================================================================
module cond_flag_bank
    import cond_flag_bank_pkg::*;
#(
    parameter  int NUM_BANKS = 4,
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [3:0]        wr_mask,
    input  logic              n,
    input  logic              z,
    input  logic              c,
    input  logic              v,
    input  logic              rd_en,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [3:0]        cond,
    output logic              out,
    output logic              out_valid,
    output logic [3:0]        flags_out
);

    logic [3:0] r_bank [NUM_BANKS];
    logic       r_out;
    logic       r_out_valid;
    logic [3:0] r_flags_out;

    logic [3:0] w_wr_flags;
    logic [3:0] w_stored;
    logic       w_rd_hit;
    logic [3:0] w_src;
    logic       w_eval;

    assign w_wr_flags = {n, z, c, v};

    // An out-of-range wr_bank matches no bank, so the write simply drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                r_bank[i] <= 4'b0000;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (wr_bank == BANK_W'(i)) begin
                    r_bank[i] <= merge_flags(r_bank[i], w_wr_flags, wr_mask);
                end
            end
        end
    end

    // Read mux; w_rd_hit stays low when rd_bank addresses no real bank.
    always_comb begin
        w_stored = 4'b0000;
        w_rd_hit = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (rd_bank == BANK_W'(i)) begin
                w_stored = r_bank[i];
                w_rd_hit = 1'b1;
            end
        end
    end

`ifdef FLAG_BYPASS_EN
    // Forward this edge's write so the evaluation sees the post-write flags.
    always_comb begin
        w_src = w_stored;
        if (wr_en && w_rd_hit && (wr_bank == rd_bank)) begin
            w_src = merge_flags(w_stored, w_wr_flags, wr_mask);
        end
    end
`else
    assign w_src = w_stored;
`endif

    cond_eval u_cond_eval (
        .cond   (cond),
        .flags  (w_src),
        .result (w_eval)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_flags_out <= 4'b0000;
        end else if (rd_en) begin
            r_out       <= w_rd_hit & w_eval;
            r_flags_out <= w_rd_hit ? w_src : 4'b0000;
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign flags_out = r_flags_out;

endmodule
`default_nettype wire

// File: tb/tb_cond_flag_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cond_flag_bank
//  Description : Directed self-checking bench for cond_flag_bank with
//                NUM_BANKS=3 (bank index 3 is out of range). Expected values
//                honour FLAG_BYPASS_EN when the bench is built with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_flag_bank;
    import cond_flag_bank_pkg::*;

    localparam int NUM_BANKS = 3;
    localparam int BANK_W    = 2;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [3:0]        wr_mask;
    logic              n, z, c, v;
    logic              rd_en;
    logic [BANK_W-1:0] rd_bank;
    logic [3:0]        cond;
    logic              out;
    logic              out_valid;
    logic [3:0]        flags_out;

    int total;
    int bad;

    cond_flag_bank #(.NUM_BANKS(NUM_BANKS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_bank   (wr_bank),
        .wr_mask   (wr_mask),
        .n         (n),
        .z         (z),
        .c         (c),
        .v         (v),
        .rd_en     (rd_en),
        .rd_bank   (rd_bank),
        .cond      (cond),
        .out       (out),
        .out_valid (out_valid),
        .flags_out (flags_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and settle; outputs are then sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_write(input logic [1:0] bank, input logic [3:0] nzcv,
                             input logic [3:0] mask);
        wr_en = 1'b1; wr_bank = bank; wr_mask = mask;
        {n, z, c, v} = nzcv;
    endtask

    task automatic set_read(input logic [1:0] bank, input cond_e cc);
        rd_en = 1'b1; rd_bank = bank; cond = cc;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] bank, input logic [3:0] nzcv,
                            input logic [3:0] mask);
        set_write(bank, nzcv, mask);
        tick();
        idle();
    endtask

    task automatic do_eval(input logic [1:0] bank, input cond_e cc);
        set_read(bank, cc);
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        wr_bank = '0; wr_mask = '0; {n, z, c, v} = 4'b0000;
        rd_bank = '0; cond = 4'd0;
        tick(); tick();
        total++; if (out !== 1'b0) begin bad++; $display("FAIL reset_out got=%b exp=0", out); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (flags_out !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags_out); end
        rst_n = 1'b1;
        tick();
        do_write(2'd0, 4'b1111, 4'b1111);
        do_eval(2'd0, ALWAYS);
        total++; if (out !== 1'b1) begin bad++; $display("FAIL pre_reset_out got=%b exp=1", out); end
        total++; if (flags_out !== 4'b1111) begin bad++; $display("FAIL pre_reset_flags got=%b exp=1111", flags_out); end
        // Asynchronous reset with out=1 and out_valid=1, between edges.
        rst_n = 1'b0;
        #1;
        total++; if (out !== 1'b0) begin bad++; $display("FAIL async_reset_out got=%b exp=0", out); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid got=%b exp=0", out_valid); end
        tick();
        rst_n = 1'b1;
        tick();
        do_eval(2'd0, ALWAYS);
        total++; if (out !== 1'b1) begin bad++; $display("FAIL post_reset_always got=%b exp=1", out); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL post_reset_valid got=%b exp=1", out_valid); end
        total++; if (flags_out !== 4'b0000) begin bad++; $display("FAIL post_reset_bank_cleared got=%b exp=0000", flags_out); end
        do_eval(2'd0, EQUAL);
        total++; if (out !== 1'b0) begin bad++; $display("FAIL post_reset_equal got=%b exp=0", out); end
    endtask

    task automatic test_bank_isolation();
        do_write(2'd2, 4'b0100, 4'b1111);
        do_write(2'd1, 4'b1000, 4'b1111);
        do_eval(2'd2, EQUAL);
        total++; if (out !== 1'b1) begin bad++; $display("FAIL iso_b2_equal got=%b exp=1", out); end
        total++; if (flags_out !== 4'b0100) begin bad++; $display("FAIL iso_b2_flags got=%b exp=0100", flags_out); end
        do_eval(2'd1, EQUAL);
        total++; if (out !== 1'b0) begin bad++; $display("FAIL iso_b1_equal got=%b exp=0", out); end
        do_eval(2'd1, LESS);
        total++; if (out !== 1'b1) begin bad++; $display("FAIL iso_b1_less got=%b exp=1", out); end
        total++; if (flags_out !== 4'b1000) begin bad++; $display("FAIL iso_b1_flags got=%b exp=1000", flags_out); end
        do_eval(2'd3, GREATER);
        total++; if (out !== 1'b0) begin bad++; $display("FAIL iso_b3_greater got=%b exp=0", out); end
        total++; if (flags_out !== 4'b0000) begin bad++; $display("FAIL iso_b3_flags got=%b exp=0000", flags_out); end
        do_eval(2'd0, POSITIVE);
        total++; if (flags_out !== 4'b0000) begin bad++; $display("FAIL iso_b0_flags got=%b exp=0000", flags_out); end
    endtask

    task automatic test_masked_write();
        do_write(2'd0, 4'b1001, 4'b1111);
        do_write(2'd0, 4'b0110, 4'b0010);
        do_eval(2'd0, LESS);
        total++; if (flags_out !== 4'b1011) begin bad++; $display("FAIL mask_flags got=%b exp=1011", flags_out); end
        total++; if (out !== 1'b0) begin bad++; $display("FAIL mask_less got=%b exp=0", out); end
        do_eval(2'd0, HIGHER);
        total++; if (out !== 1'b1) begin bad++; $display("FAIL mask_higher got=%b exp=1", out); end
        do_write(2'd0, 4'b0100, 4'b0000);
        do_eval(2'd0, CARRY_SET);
        total++; if (flags_out !== 4'b1011) begin bad++; $display("FAIL mask_zero_flags got=%b exp=1011", flags_out); end
        total++; if (out !== 1'b1) begin bad++; $display("FAIL mask_zero_carry got=%b exp=1", out); end
    endtask

    task automatic test_signed_compare();
        // Index = {N,Z,V}; entry = {GREATER, GREATER_EQ, LESS, LESS_EQ}.
        logic [3:0] exp_tab [8];
        logic [3:0] e;
        logic [2:0] nzv;
        cond_e      ccs [4];
        exp_tab = '{4'b1100, 4'b0011, 4'b0101, 4'b0011,
                    4'b0011, 4'b1100, 4'b0011, 4'b0101};
        ccs = '{GREATER, GREATER_EQ, LESS, LESS_EQ};
        for (int k = 0; k < 8; k++) begin
            nzv = 3'(k);
            e   = exp_tab[k];
            do_write(2'd2, {nzv[2], nzv[1], 1'b0, nzv[0]}, 4'b1111);
            for (int j = 0; j < 4; j++) begin
                do_eval(2'd2, ccs[j]);
                total++;
                if (out !== e[3-j]) begin
                    bad++;
                    $display("FAIL signed nzv=%b cond=%0d got=%b exp=%b", nzv, ccs[j], out, e[3-j]);
                end
            end
        end
    endtask

    task automatic test_bypass();
        logic exp_now;
        logic [3:0] exp_flags;
`ifdef FLAG_BYPASS_EN
        exp_now = 1'b1; exp_flags = 4'b0100;
`else
        exp_now = 1'b0; exp_flags = 4'b0000;
`endif
        do_write(2'd1, 4'b0000, 4'b1111);
        set_write(2'd1, 4'b0100, 4'b0100);
        set_read(2'd1, EQUAL);
        tick();
        idle();
        total++; if (out !== exp_now) begin bad++; $display("FAIL bypass_same_cycle got=%b exp=%b", out, exp_now); end
        total++; if (flags_out !== exp_flags) begin bad++; $display("FAIL bypass_flags got=%b exp=%b", flags_out, exp_flags); end
        do_eval(2'd1, EQUAL);
        total++; if (out !== 1'b1) begin bad++; $display("FAIL bypass_next_cycle got=%b exp=1", out); end
        // Write to bank 0 alongside a read of bank 2 (holds 1101): no interaction.
        set_write(2'd0, 4'b0000, 4'b1111);
        set_read(2'd2, NEGATIVE);
        tick();
        idle();
        total++; if (flags_out !== 4'b1101) begin bad++; $display("FAIL diff_bank_flags got=%b exp=1101", flags_out); end
        do_write(2'd0, 4'b1011, 4'b1111);
    endtask

    task automatic test_range();
        do_eval(2'd0, ALWAYS);
        do_eval(2'd3, ALWAYS);
        total++; if (out !== 1'b0) begin bad++; $display("FAIL range_rd_out got=%b exp=0", out); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL range_rd_valid got=%b exp=1", out_valid); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL range_valid_drop got=%b exp=0", out_valid); end
        do_eval(2'd2, NEGATIVE);
        tick();
        total++; if (out !== 1'b1) begin bad++; $display("FAIL hold_out got=%b exp=1", out); end
        total++; if (flags_out !== 4'b1101) begin bad++; $display("FAIL hold_flags got=%b exp=1101", flags_out); end
        do_write(2'd3, 4'b0000, 4'b1111);
        do_eval(2'd0, ALWAYS);
        total++; if (flags_out !== 4'b1011) begin bad++; $display("FAIL range_wr_b0 got=%b exp=1011", flags_out); end
        do_eval(2'd1, ALWAYS);
        total++; if (flags_out !== 4'b0100) begin bad++; $display("FAIL range_wr_b1 got=%b exp=0100", flags_out); end
        do_eval(2'd2, ALWAYS);
        total++; if (flags_out !== 4'b1101) begin bad++; $display("FAIL range_wr_b2 got=%b exp=1101", flags_out); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] banks [4];
        cond_e      ccs   [4];
        logic       exp_o [4];
        logic [3:0] exp_f [4];
        banks = '{2'd0, 2'd1, 2'd2, 2'd0};
        ccs   = '{NEGATIVE, NEGATIVE, NEGATIVE, EQUAL};
        exp_o = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_f = '{4'b1011, 4'b0100, 4'b1101, 4'b1011};
        tick();
        for (int k = 0; k < 4; k++) begin
            set_read(banks[k], ccs[k]);
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", k, out_valid); end
            total++; if (out !== exp_o[k]) begin bad++; $display("FAIL b2b_out[%0d] got=%b exp=%b", k, out, exp_o[k]); end
            total++; if (flags_out !== exp_f[k]) begin bad++; $display("FAIL b2b_flags[%0d] got=%b exp=%b", k, flags_out, exp_f[k]); end
        end
        idle();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_end got=%b exp=0", out_valid); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_bank_isolation();
        test_masked_write();
        test_signed_compare();
        test_bypass();
        test_range();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
